// File: rtl/rip_axi_burst_tester.sv
// AXI4 burst memory tester: writes an address pattern over NUM_BURSTS
// bursts, reads it back and counts miscompares.
module rip_axi_burst_tester #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int NUM_BURSTS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] mem_head,
    output logic [1:0]            busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);
    localparam int BW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] BBYTES =
        ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
    localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);
    localparam logic [BW-1:0] LAST_BURST = BW'(NUM_BURSTS - 1);
    localparam logic [7:0] LEN = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BW-1:0]         r_burst;
    logic [8:0]            r_beat;
    logic                  r_over;

    logic                  w_last_burst;
    logic                  w_at_last;
    logic [ADDR_WIDTH-1:0] w_next_base;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [DATA_WIDTH-1:0] w_exp;
    logic                  w_beat_err;
    logic [15:0]           w_err_inc;

    assign w_last_burst = (r_burst == LAST_BURST);
    assign w_at_last    = (r_beat == LAST_BEAT);
    assign w_next_base  = r_base + BBYTES;
    assign w_next_addr  = r_addr + STEP;
    assign w_exp        = DATA_WIDTH'(r_addr);
    // Once RLAST is overdue, the remaining beats only drain the burst.
    assign w_beat_err   = !r_over &&
                          ((RDATA != w_exp) || (RLAST != w_at_last));
    assign w_err_inc    = (err_count == 16'hFFFF) ? err_count
                                                  : err_count + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_head    <= '0;
            r_base    <= '0;
            r_addr    <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
            r_over    <= 1'b0;
            busy      <= 2'b00;
            done      <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            AWADDR    <= '0;
            AWLEN     <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WLAST     <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARLEN     <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (start) begin
                    r_head    <= mem_head;
                    r_base    <= mem_head;
                    r_burst   <= '0;
                    err_count <= '0;
                    error     <= 1'b0;
                    AWADDR    <= mem_head;
                    AWLEN     <= LEN;
                    ARLEN     <= LEN;
                    AWVALID   <= 1'b1;
                    busy      <= 2'b01;
                    r_state   <= S_AW;
                end
                S_AW: if (AWREADY) begin
                    AWVALID <= 1'b0;
                    r_addr  <= r_base;
                    r_beat  <= '0;
                    WDATA   <= DATA_WIDTH'(r_base);
                    WLAST   <= (LAST_BEAT == 9'd0);
                    WVALID  <= 1'b1;
                    r_state <= S_W;
                end
                S_W: if (WREADY) begin
                    if (WLAST) begin
                        WVALID  <= 1'b0;
                        WLAST   <= 1'b0;
                        BREADY  <= 1'b1;
                        r_state <= S_B;
                    end else begin
                        r_addr <= w_next_addr;
                        r_beat <= r_beat + 9'd1;
                        WDATA  <= DATA_WIDTH'(w_next_addr);
                        WLAST  <= (r_beat + 9'd1 == LAST_BEAT);
                    end
                end
                S_B: if (BVALID) begin
                    BREADY <= 1'b0;
                    if (w_last_burst) begin
                        r_burst <= '0;
                        r_base  <= r_head;
                        ARADDR  <= r_head;
                        ARVALID <= 1'b1;
                        busy    <= 2'b10;
                        r_state <= S_AR;
                    end else begin
                        r_burst <= r_burst + BW'(1);
                        r_base  <= w_next_base;
                        AWADDR  <= w_next_base;
                        AWVALID <= 1'b1;
                        r_state <= S_AW;
                    end
                end
                S_AR: if (ARREADY) begin
                    ARVALID <= 1'b0;
                    RREADY  <= 1'b1;
                    r_addr  <= r_base;
                    r_beat  <= '0;
                    r_over  <= 1'b0;
                    r_state <= S_R;
                end
                S_R: if (RVALID) begin
                    if (w_beat_err) begin
                        err_count <= w_err_inc;
                        error     <= 1'b1;
                    end
                    if (!r_over) begin
                        r_addr <= w_next_addr;
                        r_beat <= r_beat + 9'd1;
                        r_over <= w_at_last && !RLAST;
                    end
                    if (RLAST) begin
                        RREADY <= 1'b0;
                        if (w_last_burst) begin
                            busy    <= 2'b00;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_burst <= r_burst + BW'(1);
                            r_base  <= w_next_base;
                            ARADDR  <= w_next_base;
                            ARVALID <= 1'b1;
                            r_state <= S_AR;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rip_axi_burst_tester.sv
// Testbench for rip_axi_burst_tester: reactive AXI slave memory with
// queue scoreboard, stalls, read corruption, reset and wrap cases.
module tb_rip_axi_burst_tester;
    localparam int BL = 16;
    localparam int NB = 4;
    localparam logic [31:0] BB = 32'(BL * 4);
    localparam int BUDGET = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mem_head = '0;
    logic [1:0]  busy;
    logic        done, error;
    logic [15:0] err_count;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY = 1'b0;
    logic [31:0] WDATA;
    logic        WLAST, WVALID;
    logic        WREADY = 1'b0;
    logic        BVALID = 1'b0;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [31:0] RDATA = '0;
    logic        RLAST = 1'b0;
    logic        RVALID = 1'b0;
    logic        RREADY;

    logic        start2 = 1'b0;
    logic [31:0] mem_head2 = '0;
    logic [1:0]  busy2;
    logic        done2, error2;
    logic [15:0] err_count2;
    logic [31:0] AWADDR2, WDATA2, ARADDR2;
    logic [7:0]  AWLEN2, ARLEN2;
    logic        AWVALID2, WLAST2, WVALID2, BREADY2;
    logic        ARVALID2, RREADY2;

    always #5 clk = ~clk;

    rip_axi_burst_tester dut (
        .clk(clk), .rst(rst), .start(start), .mem_head(mem_head),
        .busy(busy), .done(done), .error(error), .err_count(err_count),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID),
        .AWREADY(AWREADY), .WDATA(WDATA), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY), .BVALID(BVALID),
        .BREADY(BREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    // Single-beat bursts against an always-ready loopback slave.
    rip_axi_burst_tester #(.BURST_LEN(1), .NUM_BURSTS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mem_head(mem_head2),
        .busy(busy2), .done(done2), .error(error2),
        .err_count(err_count2),
        .AWADDR(AWADDR2), .AWLEN(AWLEN2), .AWVALID(AWVALID2),
        .AWREADY(1'b1), .WDATA(WDATA2), .WLAST(WLAST2),
        .WVALID(WVALID2), .WREADY(1'b1), .BVALID(1'b1),
        .BREADY(BREADY2), .ARADDR(ARADDR2), .ARLEN(ARLEN2),
        .ARVALID(ARVALID2), .ARREADY(1'b1), .RDATA(ARADDR2),
        .RLAST(1'b1), .RVALID(1'b1), .RREADY(RREADY2)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [255:0] outs();
        return {busy, done, error, err_count, AWADDR, AWLEN, AWVALID,
                WDATA, WLAST, WVALID, BREADY, ARADDR, ARLEN, ARVALID,
                RREADY};
    endfunction

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
    logic [31:0] exp_aw2[$], exp_w2[$], exp_ar2[$];

    bit stall = 0;
    int corrupt_left = 0;
    int rdrv = 0, wcnt = 0, ndone = 0, ndone2 = 0, wbeat = 0, rleft = 0;
    logic [31:0] wptr = '0, rptr = '0;
    bit bpend = 0, b_acc = 0, r_acc = 0;
    bit aw_hold = 0, w_hold = 0, ar_hold = 0;
    logic [63:0] aw_snap, w_snap, ar_snap;

    function automatic bit rnd();
        return stall ? ($urandom_range(0, 1) != 0) : 1'b1;
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            AWREADY = 0; WREADY = 0; ARREADY = 0;
            BVALID = 0; RVALID = 0; RLAST = 0; RDATA = '0;
            bpend = 0; b_acc = 0; r_acc = 0; rleft = 0; wbeat = 0;
            aw_hold = 0; w_hold = 0; ar_hold = 0;
        end else begin
            if (aw_hold) chk("aw_stable", {AWVALID, AWLEN, AWADDR}, aw_snap);
            if (w_hold)  chk("w_stable", {WVALID, WLAST, WDATA}, w_snap);
            if (ar_hold) chk("ar_stable", {ARVALID, ARLEN, ARADDR}, ar_snap);
            if (done) ndone++;
            if (b_acc) begin BVALID = 0; b_acc = 0; end
            if (bpend && !BVALID && rnd()) begin BVALID = 1; bpend = 0; end
            if (BVALID && BREADY) b_acc = 1;
            if (r_acc) begin
                RVALID = 0; RLAST = 0; r_acc = 0;
                rleft--; rptr += 32'd4;
            end
            if (rleft > 0 && !RVALID && rnd()) begin
                RVALID = 1; RLAST = (rleft == 1); RDATA = rd_mem(rptr);
                rdrv++;
                if (corrupt_left > 0 && rdrv % 5 == 0) begin
                    RDATA = RDATA ^ 32'h1; corrupt_left--;
                end
            end
            if (RVALID && RREADY) r_acc = 1;
            AWREADY = rnd();
            aw_hold = AWVALID && !AWREADY;
            aw_snap = 64'({AWVALID, AWLEN, AWADDR});
            if (AWVALID && AWREADY) begin
                chk("awaddr", AWADDR,
                    exp_aw.size() ? exp_aw.pop_front() : 32'hx);
                chk("awlen", AWLEN, 8'(BL - 1));
                wptr = AWADDR;
            end
            WREADY = rnd();
            w_hold = WVALID && !WREADY;
            w_snap = 64'({WVALID, WLAST, WDATA});
            if (WVALID && WREADY) begin
                chk("wdata", WDATA,
                    exp_w.size() ? exp_w.pop_front() : 32'hx);
                chk("wlast", WLAST, wbeat == BL - 1);
                wbeat = (wbeat == BL - 1) ? 0 : wbeat + 1;
                mem[wptr] = WDATA; wptr += 32'd4; wcnt++;
                if (WLAST) bpend = 1;
            end
            ARREADY = rnd();
            ar_hold = ARVALID && !ARREADY;
            ar_snap = 64'({ARVALID, ARLEN, ARADDR});
            if (ARVALID && ARREADY) begin
                chk("araddr", ARADDR,
                    exp_ar.size() ? exp_ar.pop_front() : 32'hx);
                chk("arlen", ARLEN, 8'(BL - 1));
                rptr = ARADDR; rleft = int'(ARLEN) + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done2) ndone2++;
            if (AWVALID2) begin
                chk("aw2addr", AWADDR2,
                    exp_aw2.size() ? exp_aw2.pop_front() : 32'hx);
                chk("aw2len", AWLEN2, 8'h00);
            end
            if (WVALID2) begin
                chk("w2data", WDATA2,
                    exp_w2.size() ? exp_w2.pop_front() : 32'hx);
                chk("w2last", WLAST2, 1'b1);
            end
            if (ARVALID2)
                chk("ar2addr", ARADDR2,
                    exp_ar2.size() ? exp_ar2.pop_front() : 32'hx);
        end
    end

    task automatic push_exp(input logic [31:0] head);
        for (int b = 0; b < NB; b++) begin
            exp_aw.push_back(head + BB * 32'(b));
            exp_ar.push_back(head + BB * 32'(b));
        end
        for (int i = 0; i < NB * BL; i++)
            exp_w.push_back(head + 32'(i * 4));
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < BUDGET) begin @(posedge clk); #1; t++; end
        chk(tag, t < BUDGET, 1'b1);
    endtask

    task automatic check_mem(input logic [31:0] head);
        chk("mem_size", mem.size(), NB * BL);
        for (int i = 0; i < NB * BL; i++) begin
            logic [31:0] a;
            a = head + 32'(i * 4);
            chk("mem", mem.exists(a) ? mem[a] : 32'hx, a);
        end
    endtask

    task automatic do_pass(input logic [31:0] head, input string tag,
                           input int exp_err);
        int d0;
        mem.delete();
        push_exp(head);
        d0 = ndone;
        mem_head = head; start = 1;
        @(posedge clk); #1 start = 0;
        wait_done({tag, "_timeout"});
        repeat (3) @(posedge clk); #1;
        chk({tag, "_done_cnt"}, ndone - d0, 1);
        chk({tag, "_err_count"}, err_count, 16'(exp_err));
        chk({tag, "_error"}, error, exp_err != 0);
        chk({tag, "_busy"}, busy, 2'b00);
        chk({tag, "_sb_left"}, exp_aw.size() + exp_w.size()
            + exp_ar.size(), 0);
        check_mem(head);
    endtask

    initial begin
        int t, d0;
        repeat (3) @(posedge clk); #1;
        chk("rst_outs", outs(), '0);
        rst = 0;
        @(posedge clk); #1;
        chk("idle_outs", outs(), '0);

        do_pass(32'h0000_1000, "base", 0);
        stall = 1;
        do_pass(32'h0000_1000, "stall", 0);
        stall = 0;
        corrupt_left = 3; rdrv = 0;
        do_pass(32'h0000_2000, "corrupt", 3);
        chk("corrupt_used", corrupt_left, 0);
        do_pass(32'hFFFF_FF80, "wrap", 0);

        mem.delete(); push_exp(32'h3000); wcnt = 0;
        mem_head = 32'h3000; start = 1;
        @(posedge clk); #1 start = 0;
        t = 0;
        while (wcnt < 5 && t < BUDGET) begin @(posedge clk); #1; t++; end
        chk("w5_timeout", t < BUDGET, 1'b1);
        chk("w5_state", {busy, WVALID, WDATA}, {3'b011, 32'h3014});
        rst = 1;
        @(posedge clk); #1;
        chk("midrst_outs", outs(), '0);
        rst = 0;
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        @(posedge clk); #1;
        do_pass(32'h0000_3000, "after_rst", 0);

        mem.delete(); push_exp(32'h4000); push_exp(32'h4000);
        d0 = ndone; mem_head = 32'h4000; start = 1;
        wait_done("hold_timeout1");
        @(posedge clk); #1;
        chk("hold_idle", {busy, done, AWVALID}, 4'b0000);
        @(posedge clk); #1;
        chk("hold_restart", {busy, AWVALID}, 3'b011);
        wait_done("hold_timeout2");
        start = 0;
        repeat (4) @(posedge clk); #1;
        chk("hold_passes", ndone - d0, 2);
        chk("hold_error", {error, err_count}, 17'h0);
        chk("hold_sb_left", exp_aw.size() + exp_w.size()
            + exp_ar.size(), 0);

        exp_aw2.push_back(32'hFFFF_FFFC); exp_aw2.push_back(32'h0);
        exp_w2.push_back(32'hFFFF_FFFC);  exp_w2.push_back(32'h0);
        exp_ar2.push_back(32'hFFFF_FFFC); exp_ar2.push_back(32'h0);
        d0 = ndone2; mem_head2 = 32'hFFFF_FFFC; start2 = 1;
        @(posedge clk); #1 start2 = 0;
        t = 0;
        while (ndone2 == d0 && t < 200) begin @(posedge clk); #1; t++; end
        chk("bl1_timeout", t < 200, 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("bl1_done_cnt", ndone2 - d0, 1);
        chk("bl1_error", {error2, err_count2}, 17'h0);
        chk("bl1_sb_left", exp_aw2.size() + exp_w2.size()
            + exp_ar2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
